my_multiplier_core: RTL and testbench

//  Iterative radix-2 shift-add multiplier engine. Sits directly downstream of the
//  S00_AXI AXI4-Lite register slave in my_multiplier_v1_0.
//  - Slave takes operands from a packed register write, {op_a[31:16], op_b[15:0]}.
//  - Core returns the product and a completion count for read-back over the same slave.

---
 rtl/my_multiplier_core.sv | 119 +++++++++++
 tb/tb_my_multiplier_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/my_multiplier_core.sv
// my_multiplier_core: iterative radix-2 shift-add multiplier.
// Accepts one operand pair per handshake, produces a 2*OP_WIDTH product after a
// fixed OP_WIDTH-cycle RUN phase, and counts products handed downstream.
module my_multiplier_core #(
  parameter int unsigned OP_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [OP_WIDTH-1:0]     s_op_a,
  input  logic [OP_WIDTH-1:0]     s_op_b,
  input  logic                    s_signed,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*OP_WIDTH-1:0]   m_product,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    op_count
);

  localparam int unsigned PW = 2 * OP_WIDTH;
  localparam int unsigned CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(OP_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [PW-1:0]        r_acc;
  logic [PW-1:0]        r_mcand;
  logic [OP_WIDTH-1:0]  r_mplier;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [PW-1:0]        r_product;
  logic [CNT_WIDTH-1:0] r_op_count;

  logic                 w_accept;
  logic                 w_handoff;
  logic [OP_WIDTH-1:0]  w_a_mag;
  logic [OP_WIDTH-1:0]  w_b_mag;
  logic                 w_neg;
  logic [PW-1:0]        w_acc_next;

  assign s_ready   = (r_state == S_IDLE) && !ARESET;
  assign m_valid   = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign m_product = r_product;
  assign op_count  = r_op_count;

  assign w_accept  = s_valid && s_ready;
  assign w_handoff = m_valid && m_ready;

  // Operand magnitudes and result sign; the most-negative value maps to 2^(OP_WIDTH-1).
  always_comb begin
    w_a_mag = s_op_a;
    w_b_mag = s_op_b;
    w_neg   = 1'b0;
    if (s_signed) begin
      if (s_op_a[OP_WIDTH-1]) w_a_mag = '0 - s_op_a;
      if (s_op_b[OP_WIDTH-1]) w_b_mag = '0 - s_op_b;
      w_neg = s_op_a[OP_WIDTH-1] ^ s_op_b[OP_WIDTH-1];
    end
  end

  // Accumulator value after the current RUN step; the multiplicand register
  // is pre-shifted so it already equals multiplicand << count.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) w_acc_next = r_acc + r_mcand;
  end

  // Control state machine, shift-add datapath and completion counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_product  <= '0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= {{OP_WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // The final step folds the sign fix-up in so DONE follows directly.
          if (r_cnt == LAST_BIT) begin
            r_product <= r_neg ? ('0 - w_acc_next) : w_acc_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_handoff) begin
            r_op_count <= r_op_count + CNT_WIDTH'(1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_multiplier_core.sv
// Directed testbench for my_multiplier_core with hand-computed expectations.
module tb_my_multiplier_core;

  logic        ACLK;
  logic        ARESET;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_op_a;
  logic [15:0] s_op_b;
  logic        s_signed;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_product;
  logic        busy;
  logic [7:0]  op_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  my_multiplier_core #(.OP_WIDTH(16), .CNT_WIDTH(8)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_op_a    (s_op_a),
    .s_op_b    (s_op_b),
    .s_signed  (s_signed),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_product (m_product),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present operands at a negedge; returns at the negedge after the accept cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sg);
    int unsigned n;
    n = 0;
    s_op_a = a; s_op_b = b; s_signed = sg; s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk("accept_in_time", 64'(n < 100), 64'd1);
    @(negedge ACLK);
    s_valid = 1'b0;
  endtask

  // Counts negedges since the accept cycle until m_valid is seen.
  task automatic wait_valid(input int unsigned start, output int unsigned lat);
    lat = start;
    while (!m_valid && lat < 100) begin
      @(negedge ACLK);
      lat++;
    end
  endtask

  task automatic handoff();
    m_ready = 1'b1;
    @(negedge ACLK);
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(m_product), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sg;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int unsigned lat;
    int unsigned cyc;
    int unsigned hs;
    int unsigned ho;
    int unsigned first_hs;
    int unsigned last_hs;
    logic [31:0] held;

    ARESET = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s_op_a = '0; s_op_b = '0; s_signed = 1'b0;

    vecs[0] = '{16'h0101, 16'hFFFF, 1'b0, 32'h0100FEFF};
    vecs[1] = '{16'h0101, 16'hFFFF, 1'b1, 32'hFFFFFEFF};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};

    @(negedge ACLK);
    do_reset();

    // Directed products, latency and counter
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sg);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_s_ready", 64'(s_ready), 64'd0);
      wait_valid(1, lat);
      chk("latency", 64'(lat), 64'd17);
      chk("product", 64'(m_product), 64'(vecs[i].exp));
      handoff();
      chk("after_handoff_m_valid", 64'(m_valid), 64'd0);
      chk("op_count", 64'(op_count), 64'(i + 1));
      chk("product_kept", 64'(m_product), 64'(vecs[i].exp));
    end

    // Back-pressure in DONE
    start_op(16'd100, 16'd200, 1'b0);
    wait_valid(1, lat);
    held = m_product;
    chk("bp_product", 64'(held), 64'd20000);
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      chk("bp_stable", 64'(m_product), 64'd20000);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      chk("bp_op_count", 64'(op_count), 64'd4);
    end
    handoff();
    chk("bp_op_count_after", 64'(op_count), 64'd5);

    // Reset in the middle of RUN
    start_op(16'h1234, 16'h5678, 1'b0);
    repeat (4) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_s_ready_after", 64'(s_ready), 64'd1);
    start_op(16'd7, 16'hFFF7, 1'b1);
    wait_valid(1, lat);
    chk("midrst_latency", 64'(lat), 64'd17);
    chk("midrst_product", 64'(m_product), 64'hFFFFFFC1);
    handoff();
    chk("midrst_op_count_new", 64'(op_count), 64'd1);

    // Zero operand, with a stray s_valid pulse during RUN
    start_op(16'h0000, 16'h1234, 1'b0);
    lat = 1;
    repeat (3) begin @(negedge ACLK); lat++; end
    s_op_a = 16'hFFFF; s_op_b = 16'hFFFF; s_valid = 1'b1;
    @(negedge ACLK); lat++;
    s_valid = 1'b0;
    wait_valid(lat, lat);
    chk("zero_latency", 64'(lat), 64'd17);
    chk("zero_product", 64'(m_product), 64'd0);
    handoff();
    chk("zero_no_new_op", 64'(busy), 64'd0);
    @(negedge ACLK);
    chk("zero_still_idle", 64'(busy), 64'd0);
    chk("zero_op_count", 64'(op_count), 64'd2);

    // Counter wrap: 256 back-to-back operations
    do_reset();
    s_op_a = 16'd3; s_op_b = 16'd5; s_signed = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    cyc = 0; hs = 0; ho = 0; first_hs = 0; last_hs = 0;
    while (ho < 256 && cyc < 6000) begin
      if (s_valid && s_ready) begin
        if (hs == 0) first_hs = cyc;
        last_hs = cyc;
        hs++;
      end
      if (m_valid && m_ready) begin
        if (ho == 0) chk("wrap_first_product", 64'(m_product), 64'd15);
        ho++;
        if (ho == 256) s_valid = 1'b0;
      end
      @(negedge ACLK);
      cyc++;
    end
    m_ready = 1'b0;
    chk("wrap_handoffs", 64'(ho), 64'd256);
    chk("wrap_accepts", 64'(hs), 64'd256);
    chk("wrap_spacing", 64'(last_hs - first_hs), 64'(255 * 18));
    chk("wrap_op_count", 64'(op_count), 64'd0);
    chk("wrap_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
